// File: rtl/nexys_starship_repair_bank.sv
// Bank of NUM_SYS breakable starship subsystems. A broken channel holds a repair code and must be
// fixed with a matching hex_combo before its repair timer runs out; any expiry ends the round.
module nexys_starship_repair_bank #(
   parameter int NUM_SYS        = 4,
   parameter int COMBO_W        = 4,
   parameter int REPAIR_TIMEOUT = 1000,
   parameter int PENALTY        = 100
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       play_flag,
   input  logic                       gameover_ctrl,
   input  logic [NUM_SYS-1:0]         break_req,
   input  logic [COMBO_W-1:0]         random_hex,
   input  logic [COMBO_W-1:0]         hex_combo,
   input  logic [NUM_SYS-1:0]         submit,
   output logic [NUM_SYS-1:0]         broken,
   output logic [NUM_SYS*COMBO_W-1:0] combo_flat,
   output logic [NUM_SYS-1:0]         repair_ok,
   output logic [NUM_SYS-1:0]         repair_fail,
   output logic                       expired,
   output logic                       q_Init,
   output logic                       q_Play,
   output logic                       q_Done
);

   localparam int            TW    = (REPAIR_TIMEOUT > 1) ? $clog2(REPAIR_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(REPAIR_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_INIT = 3'b001,
      S_PLAY = 3'b010,
      S_DONE = 3'b100
   } state_t;

   state_t                     state, state_nxt;
   logic [TW-1:0]              timer     [NUM_SYS];
   logic [TW-1:0]              timer_nxt [NUM_SYS];
   logic [NUM_SYS-1:0]         broken_nxt, ok_nxt, fail_nxt, expire_vec;
   logic [NUM_SYS*COMBO_W-1:0] combo_nxt;
   int                         bumped;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (play_flag) state_nxt = S_PLAY;
         S_PLAY:  if (gameover_ctrl || (|expire_vec)) state_nxt = S_DONE;
         S_DONE:  if (!play_flag) state_nxt = S_INIT;
         default: state_nxt = S_INIT;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
   always_comb begin
      broken_nxt = broken;
      combo_nxt  = combo_flat;
      ok_nxt     = '0;
      fail_nxt   = '0;
      expire_vec = '0;
      bumped     = 0;
      for (int i = 0; i < NUM_SYS; i++) timer_nxt[i] = timer[i];

      case (state)
         S_INIT: begin
            broken_nxt = '0;
            combo_nxt  = '0;
            for (int i = 0; i < NUM_SYS; i++) timer_nxt[i] = '0;
         end
         S_PLAY: begin
            for (int i = 0; i < NUM_SYS; i++) begin
               if (!broken[i]) begin
                  if (break_req[i]) begin
                     broken_nxt[i]                   = 1'b1;
                     combo_nxt[i*COMBO_W +: COMBO_W] = random_hex;
                     timer_nxt[i]                    = '0;
                  end
               end else if (submit[i] && (hex_combo == combo_flat[i*COMBO_W +: COMBO_W])) begin
                  // A correct submit beats an expiry landing on the same edge.
                  broken_nxt[i] = 1'b0;
                  ok_nxt[i]     = 1'b1;
                  timer_nxt[i]  = '0;
               end else begin
                  if (timer[i] == T_MAX) expire_vec[i] = 1'b1;
                  if (submit[i]) begin
                     fail_nxt[i]  = 1'b1;
                     bumped       = int'(timer[i]) + PENALTY + 1;
                     timer_nxt[i] = (bumped >= REPAIR_TIMEOUT - 1) ? T_MAX : TW'(bumped);
                  end else if (timer[i] != T_MAX) begin
                     timer_nxt[i] = timer[i] + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // NOTE: the per-channel timer array is small register state, so it is reset like any flop.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         broken      <= '0;
         combo_flat  <= '0;
         repair_ok   <= '0;
         repair_fail <= '0;
         expired     <= 1'b0;
         for (int i = 0; i < NUM_SYS; i++) timer[i] <= '0;
      end else begin
         broken      <= broken_nxt;
         combo_flat  <= combo_nxt;
         repair_ok   <= ok_nxt;
         repair_fail <= fail_nxt;
         expired     <= |expire_vec;
         for (int i = 0; i < NUM_SYS; i++) timer[i] <= timer_nxt[i];
      end
   end

   always_comb begin
      q_Init = (state == S_INIT);
      q_Play = (state == S_PLAY);
      q_Done = (state == S_DONE);
   end

endmodule
